div_unit: RTL and testbench

//  Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.

---
 rtl/div_unit.sv | 149 ++++++++++++++
 tb/tb_div_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// One quotient bit per cycle over WIDTH cycles; the sign-corrected quotient (LO) and
// remainder (HI) are registered on entry to DONE, together with a one-cycle ready pulse.
// div_stall holds E/D/F from the start cycle until the result is available.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor seen in IDLE skips the iteration
// and goes straight to DONE with the forced divide-by-zero result.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             div_stall,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      counter;
    logic [WIDTH:0]     rem;      // one extra bit so the trial subtract sign is visible
    logic [WIDTH-1:0]   quo;      // dividend magnitude shifts out, quotient bits shift in
    logic [WIDTH-1:0]   dvsr;
    logic [WIDTH-1:0]   a_raw;    // raw dividend, returned as remainder on divide-by-zero
    logic               sign_q;
    logic               sign_r;
    logic               b_zero;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   q_fin;
    logic [WIDTH-1:0]   r_fin;
    logic               last_iter;

    // Operand magnitudes; only signed divides take the absolute value.
    always_comb begin
        mag_a = a;
        mag_b = b;
        if (signedE && a[WIDTH-1]) mag_a = -a;
        if (signedE && b[WIDTH-1]) mag_b = -b;
    end

    // One restoring step: shift {rem,quo} left, trial-subtract, restore when negative.
    always_comb begin
        rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial   = rem_sh - {1'b0, dvsr};
        rem_nxt = trial[WIDTH] ? rem_sh : trial;
        quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

    // Final result after the last step: sign correction, or the forced zero-divisor result.
    always_comb begin
        q_fin = sign_q ? -quo_nxt : quo_nxt;
        r_fin = sign_r ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
        if (b_zero) begin
            q_fin = {WIDTH{1'b1}};
            r_fin = a_raw;
        end
    end

    assign last_iter = (counter == CW'(WIDTH - 1));

    // Stall is combinational so the cycle that first sees the divide already holds the pipe.
    assign div_stall = ((state == IDLE) && startE && !annul) || (state == BUSY);

    // Divider FSM; annul beats everything and leaves the result registers untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            counter   <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            a_raw     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            b_zero    <= 1'b0;
            ready     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            ready <= 1'b0;
            if (annul) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (startE) begin
                            rem     <= '0;
                            quo     <= mag_a;
                            dvsr    <= mag_b;
                            a_raw   <= a;
                            sign_q  <= signedE & (a[WIDTH-1] ^ b[WIDTH-1]);
                            sign_r  <= signedE & a[WIDTH-1];
                            b_zero  <= (b == '0);
                            counter <= '0;
`ifdef DIV_ZERO_FAST_EN
                            if (b == '0) begin
                                state     <= DONE;
                                ready     <= 1'b1;
                                quotient  <= {WIDTH{1'b1}};
                                remainder <= a;
                            end else begin
                                state <= BUSY;
                            end
`else
                            state <= BUSY;
`endif
                        end
                    end
                    BUSY: begin
                        rem     <= rem_nxt;
                        quo     <= quo_nxt;
                        counter <= counter + 1'b1;
                        if (last_iter) begin
                            state     <= DONE;
                            ready     <= 1'b1;
                            quotient  <= q_fin;
                            remainder <= r_fin;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with a cycle-level reference model and a
// per-cycle compare process, plus hand-computed literal expectations.
module tb_div_unit;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         startE;
    logic         signedE;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         annul;
    logic         div_stall;
    logic         ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .startE    (startE),
        .signedE   (signedE),
        .a         (a),
        .b         (b),
        .annul     (annul),
        .div_stall (div_stall),
        .ready     (ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: magnitudes, unsigned divide, then two's-complement sign fix.
    function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic s, output logic [W-1:0] q,
                                    output logic [W-1:0] r);
        logic [W-1:0] mx;
        logic [W-1:0] my;
        if (y == '0) begin
            q = '1;
            r = x;
        end else begin
            mx = (s && x[W-1]) ? -x : x;
            my = (s && y[W-1]) ? -y : y;
            q  = mx / my;
            r  = mx % my;
            if (s && (x[W-1] ^ y[W-1])) q = -q;
            if (s && x[W-1]) r = -r;
        end
    endfunction

    // Cycle-level model: m_left = busy cycles still to come, m_ready = result cycle.
    int           m_left  = 0;
    bit           m_ready = 1'b0;
    logic [W-1:0] m_q     = '0;
    logic [W-1:0] m_r     = '0;
    logic [W-1:0] p_q     = '0;
    logic [W-1:0] p_r     = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left  = 0;
            m_ready = 1'b0;
            m_q     = '0;
            m_r     = '0;
        end else if (m_ready) begin
            m_ready = 1'b0;
            m_left  = 0;
        end else if (annul) begin
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                m_q     = p_q;
                m_r     = p_r;
            end
        end else if (startE) begin
            ref_div(a, b, signedE, p_q, p_r);
            if (FAST && b == '0) begin
                m_ready = 1'b1;
                m_q     = p_q;
                m_r     = p_r;
            end else begin
                m_left = W;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = (m_left > 0) || (!m_ready && m_left == 0 && startE && !annul);
        chk("model_stall", W'(div_stall), W'(exp_stall));
        chk("model_ready", W'(ready), W'(m_ready));
        chk("model_quotient", quotient, m_q);
        chk("model_remainder", remainder, m_r);
    end

    // Issue one divide; optionally keep startE high while busy; report cycle of ready.
    task automatic run_div(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                           input bit hold, output int lat);
        @(posedge clk); #1;
        a = ta; b = tb_; signedE = ts; startE = 1'b1;
        #1 chk("stall_cycle0", W'(div_stall), W'(1));
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (!hold) begin
                startE = 1'b0;
                a = $urandom;
                b = $urandom;
            end
            if (ready) begin
                lat = c;
                break;
            end
        end
        startE = 1'b0;
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: no ready within 100 cycles, expected one");
        end
    endtask

    int lat;
    int ready_seen;

    initial begin
        rst = 1'b0; startE = 1'b0; signedE = 1'b0; annul = 1'b0; a = '0; b = '0;
        @(negedge clk);
        chk("reset_q", quotient, 32'h0);
        chk("reset_r", remainder, 32'h0);
        chk("reset_ready", W'(ready), W'(0));
        chk("reset_stall", W'(div_stall), W'(0));
        @(posedge clk); #1 rst = 1'b1;

        // DIVU 7/2
        run_div(32'd7, 32'd2, 1'b0, 1'b0, lat);
        chk("t1_lat", W'(lat), W'(33));
        chk("t1_q", quotient, 32'd3);
        chk("t1_r", remainder, 32'd1);
        // restart with the same operands recomputes the same result
        run_div(32'd7, 32'd2, 1'b0, 1'b1, lat);
        chk("t1b_q", quotient, 32'd3);
        chk("t1b_r", remainder, 32'd1);

        // DIV -7/2, startE held through the busy phase
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, lat);
        chk("t2_lat", W'(lat), W'(33));
        chk("t2_q", quotient, 32'hFFFF_FFFD);
        chk("t2_r", remainder, 32'hFFFF_FFFF);

        // signed overflow wraps
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
        chk("t3_q", quotient, 32'h8000_0000);
        chk("t3_r", remainder, 32'h0);

        // same bits as unsigned
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
        chk("t3u_q", quotient, 32'h0);
        chk("t3u_r", remainder, 32'h8000_0000);

        // DIV 7/-2 : q=-3, r=+1
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, lat);
        chk("tneg_q", quotient, 32'hFFFF_FFFD);
        chk("tneg_r", remainder, 32'd1);

        // large unsigned
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, lat);
        chk("tmax_q", quotient, 32'hFFFF_FFFF);
        chk("tmax_r", remainder, 32'h0);

        // DIV by zero, signed: raw dividend back
        run_div(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0, lat);
        chk("tz_s_lat", W'(lat), FAST ? W'(1) : W'(33));
        chk("tz_s_q", quotient, 32'hFFFF_FFFF);
        chk("tz_s_r", remainder, 32'hFFFF_FFF9);

        // DIVU by zero
        run_div(32'h1234, 32'd0, 1'b0, 1'b0, lat);
        chk("t4_lat", W'(lat), FAST ? W'(1) : W'(33));
        chk("t4_q", quotient, 32'hFFFF_FFFF);
        chk("t4_r", remainder, 32'h1234);

        // annul with start in IDLE: annul wins, no stall, nothing starts
        @(posedge clk); #1;
        a = 32'd100; b = 32'd7; signedE = 1'b0; startE = 1'b1; annul = 1'b1;
        #1 chk("annul_start_stall", W'(div_stall), W'(0));
        @(posedge clk); #1;
        startE = 1'b0; annul = 1'b0;
        #1 chk("annul_start_idle", W'(div_stall), W'(0));

        // annul at cycle 10 of an in-flight divide
        @(posedge clk); #1;
        a = 32'd100; b = 32'd7; signedE = 1'b0; startE = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            startE = 1'b0;
        end
        annul = 1'b1;
        #1 chk("t5_stall_c10", W'(div_stall), W'(1));
        @(posedge clk); #1;
        annul = 1'b0;
        #1 chk("t5_stall_c11", W'(div_stall), W'(0));
        chk("t5_ready_c11", W'(ready), W'(0));
        chk("t5_q_held", quotient, 32'hFFFF_FFFF);
        chk("t5_r_held", remainder, 32'h1234);
        ready_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ready) ready_seen++;
        end
        chk("t5_no_ready", W'(ready_seen), W'(0));

        // async reset mid-divide
        @(posedge clk); #1;
        a = 32'd1000; b = 32'd3; signedE = 1'b0; startE = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            startE = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        chk("t6_q", quotient, 32'h0);
        chk("t6_r", remainder, 32'h0);
        chk("t6_ready", W'(ready), W'(0));
        chk("t6_stall", W'(div_stall), W'(0));
        @(posedge clk); #1 rst = 1'b1;
        run_div(32'd1000, 32'd3, 1'b0, 1'b0, lat);
        chk("t6_lat", W'(lat), W'(33));
        chk("t6_after_q", quotient, 32'd333);
        chk("t6_after_r", remainder, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

endmodule
